// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART byte FIFO: default entry width and depth
// exponent, width of the optional dropped-write counter, and the saturating
// update rule used by that counter.
// Optional feature macro: UART_FIFO_DROPCOUNT_EN (enables dropCount in uart_fifo).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
  localparam int unsigned DEFAULT_LENGTH_BITS = 3;
  localparam int unsigned DROP_COUNT_WIDTH    = 16;

  // Next value of the dropped-write counter. A drop in the same cycle as a
  // clear leaves a count of one, so the event that just happened is not lost.
  function automatic logic [DROP_COUNT_WIDTH-1:0] drop_count_next(
    input logic [DROP_COUNT_WIDTH-1:0] current,
    input logic                        drop,
    input logic                        clear
  );
    logic [DROP_COUNT_WIDTH-1:0] result;
    result = current;
    if (clear) begin
      result = drop ? {{(DROP_COUNT_WIDTH-1){1'b0}}, 1'b1} : {DROP_COUNT_WIDTH{1'b0}};
    end else if (drop && (current != {DROP_COUNT_WIDTH{1'b1}})) begin
      result = current + {{(DROP_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = current;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port storage array for uart_fifo: DataWidth x (1 << LengthBits).
// One synchronous write port and one synchronous read port with a registered
// read output. The array itself is not reset; only the read register is.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (read register)
//   wr_en_i/wr_addr_i/wr_data_i   write port
//   rd_en_i/rd_addr_i     read port; rd_data_o updates only when rd_en_i=1
//   rd_data_o             registered read data, holds between reads
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth  = DEFAULT_DATA_WIDTH,
  parameter int unsigned LengthBits = DEFAULT_LENGTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [LengthBits-1:0] wr_addr_i,
  input  logic [DataWidth-1:0]  wr_data_i,
  input  logic                  rd_en_i,
  input  logic [LengthBits-1:0] rd_addr_i,
  output logic [DataWidth-1:0]  rd_data_o
);

  localparam int unsigned BufferLength = 1 << LengthBits;

  logic [DataWidth-1:0] mem_q [BufferLength];
  logic [DataWidth-1:0] rd_data_q;

  // Storage write port; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: captures the pre-edge contents, so a read and a write to
  // the same slot in one cycle (full FIFO) returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= {DataWidth{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Parametrised byte FIFO between the UART shift logic and the CPU register
// interface. Same-cycle read and write, occupancy-derived status, sticky
// overflow/underflow flags and a synchronous flush.
// Optional feature macro: UART_FIFO_DROPCOUNT_EN adds a 16-bit saturating
// dropCount output counting writes dropped while full.
// Ports:
//   clk, reset (async active-low), flush (sync clear of contents and flags)
//   dataWriteEnable/dataWrite      write request and data
//   dataReadEnable                 read request
//   dataReadAck/dataRead           registered read response (one cycle later)
//   count/empty/full/almostFull    occupancy status, decoded from count only
//   overflow/underflow             sticky error flags
//   dropCount                      (only with UART_FIFO_DROPCOUNT_EN)
//   clearFlags                     sync clear of sticky flags / drop counter
// ---------------------------------------------------------------------------
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth       = DEFAULT_DATA_WIDTH,
  parameter int unsigned LengthBits      = DEFAULT_LENGTH_BITS,
  parameter int unsigned AlmostFullLevel = (1 << LengthBits) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dataWriteEnable,
  input  logic [DataWidth-1:0]  dataWrite,
  input  logic                  dataReadEnable,
  output logic                  dataReadAck,
  output logic [DataWidth-1:0]  dataRead,
  output logic [LengthBits:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almostFull,
  output logic                  overflow,
  output logic                  underflow,
`ifdef UART_FIFO_DROPCOUNT_EN
  output logic [DROP_COUNT_WIDTH-1:0] dropCount,
`endif
  input  logic                  clearFlags
);

  localparam int unsigned BufferLength = 1 << LengthBits;
  localparam logic [LengthBits:0]   FULL_COUNT        = (LengthBits+1)'(BufferLength);
  localparam logic [LengthBits:0]   ALMOST_FULL_COUNT = (LengthBits+1)'(AlmostFullLevel);
  localparam logic [LengthBits:0]   ZERO_COUNT        = {(LengthBits+1){1'b0}};
  localparam logic [LengthBits:0]   COUNT_ONE         = (LengthBits+1)'(1'b1);
  localparam logic [LengthBits-1:0] ZERO_PTR          = {LengthBits{1'b0}};
  localparam logic [LengthBits-1:0] PTR_ONE           = LengthBits'(1'b1);

  logic [LengthBits-1:0] wr_pos_q, wr_pos_d;
  logic [LengthBits-1:0] rd_pos_q, rd_pos_d;
  logic [LengthBits:0]   count_q, count_d;
  logic                  ack_q, ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic empty_s;
  logic full_s;
  logic rd_fire_s;
  logic wr_fire_s;
  logic wr_drop_s;
  logic rd_under_s;

  // Status is decoded from the registered occupancy only.
  assign empty_s = (count_q == ZERO_COUNT);
  assign full_s  = (count_q == FULL_COUNT);

  // Request qualification. A full FIFO still accepts a write when a read is
  // accepted in the same cycle; an empty FIFO never forwards a same-cycle
  // write to the read side. Flush suppresses every request.
  always_comb begin
    rd_fire_s  = 1'b0;
    wr_fire_s  = 1'b0;
    wr_drop_s  = 1'b0;
    rd_under_s = 1'b0;
    if (flush) begin
      rd_fire_s  = 1'b0;
      wr_fire_s  = 1'b0;
      wr_drop_s  = 1'b0;
      rd_under_s = 1'b0;
    end else begin
      rd_fire_s  = dataReadEnable && !empty_s;
      wr_fire_s  = dataWriteEnable && (!full_s || rd_fire_s);
      wr_drop_s  = dataWriteEnable && !wr_fire_s;
      rd_under_s = dataReadEnable && empty_s;
    end
  end

  // Next-state for pointers, occupancy, read acknowledge and sticky flags.
  always_comb begin
    wr_pos_d    = wr_pos_q;
    rd_pos_d    = rd_pos_q;
    count_d     = count_q;
    ack_d       = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_pos_d    = ZERO_PTR;
      rd_pos_d    = ZERO_PTR;
      count_d     = ZERO_COUNT;
      ack_d       = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      wr_pos_d = wr_fire_s ? (wr_pos_q + PTR_ONE) : wr_pos_q;
      rd_pos_d = rd_fire_s ? (rd_pos_q + PTR_ONE) : rd_pos_q;
      ack_d    = rd_fire_s;
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
      // A flag set in this cycle wins over clearFlags.
      if (wr_drop_s) begin
        overflow_d = 1'b1;
      end else if (clearFlags) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
      if (rd_under_s) begin
        underflow_d = 1'b1;
      end else if (clearFlags) begin
        underflow_d = 1'b0;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pos_q    <= ZERO_PTR;
      rd_pos_q    <= ZERO_PTR;
      count_q     <= ZERO_COUNT;
      ack_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_pos_q    <= wr_pos_d;
      rd_pos_q    <= rd_pos_d;
      count_q     <= count_d;
      ack_q       <= ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  uart_fifo_mem #(
    .DataWidth  (DataWidth),
    .LengthBits (LengthBits)
  ) u_mem (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (wr_fire_s),
    .wr_addr_i (wr_pos_q),
    .wr_data_i (dataWrite),
    .rd_en_i   (rd_fire_s),
    .rd_addr_i (rd_pos_q),
    .rd_data_o (dataRead)
  );

`ifdef UART_FIFO_DROPCOUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-write counter; flush and clearFlags both clear it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = {DROP_COUNT_WIDTH{1'b0}};
    end else begin
      drop_cnt_d = drop_count_next(drop_cnt_q, wr_drop_s, clearFlags);
    end
  end

  // Dropped-write counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= {DROP_COUNT_WIDTH{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropCount = drop_cnt_q;
`endif

  assign dataReadAck = ack_q;
  assign count       = count_q;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almostFull  = (count_q >= ALMOST_FULL_COUNT);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo
// Self-checking bench for uart_fifo (default parameters). A queue-based
// reference model tracks contents, read response and sticky flags; each test
// task drives stimulus and compares the DUT against that model inline.
// ---------------------------------------------------------------------------
module tb_uart_fifo;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int LB    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          we;
  logic [DW-1:0] wd;
  logic          re;
  logic          cf;
  logic          ack;
  logic [DW-1:0] rdata;
  logic [LB:0]   count;
  logic          empty, full, almost_full, ovf, unf;
`ifdef UART_FIFO_DROPCOUNT_EN
  logic [15:0]   drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ack  = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;
  int            m_drop = 0;

  always #5 clk = ~clk;

  uart_fifo #(.DataWidth(DW), .LengthBits(LB), .AlmostFullLevel(AF)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .dataWriteEnable (we),
    .dataWrite       (wd),
    .dataReadEnable  (re),
    .dataReadAck     (ack),
    .dataRead        (rdata),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .almostFull      (almost_full),
    .overflow        (ovf),
    .underflow       (unf),
`ifdef UART_FIFO_DROPCOUNT_EN
    .dropCount       (drop_count),
`endif
    .clearFlags      (cf)
  );

  // Drive one cycle, advance the model, and return 1 time unit after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic c);
    int  sz;
    bit  rd_ok, wr_ok, drop;
    we = w; wd = d; re = r; flush = f; cf = c;
    sz = mq.size();
    if (f) begin
      mq.delete();
      m_ack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_drop = 0;
    end else begin
      rd_ok = r && (sz > 0);
      wr_ok = w && ((sz < DEPTH) || rd_ok);
      drop  = w && !wr_ok;
      if (rd_ok) m_data = mq.pop_front();
      m_ack = rd_ok;
      if (wr_ok) mq.push_back(d);
      m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && sz == 0) ? 1'b1 : (c ? 1'b0 : m_unf);
      if (c) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; flush = 1'b0; cf = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ack = 1'b0; m_data = '0; m_ovf = 1'b0; m_unf = 1'b0; m_drop = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; cf = 1'b0; wd = '0;
    model_reset();
    #12;
    n_checks++;
    if ({count, empty, full, almost_full, ovf, unf, ack, rdata} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b af=%b ov=%b un=%b ack=%b d=%h, expected 0 1 0 0 0 0 0 00",
               count, empty, full, almost_full, ovf, unf, ack, rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL basic_count3: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (ack !== 1'b1 || rdata !== 8'h41 + i[7:0] || count !== 4'(2 - i)) begin
        n_fail++;
        $display("FAIL basic_read%0d: got ack=%b d=%h cnt=%0d expected 1 %h %0d", i, ack, rdata, count, 8'h41 + i[7:0], 2 - i);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b expected 1", empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, i[7:0], 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'(mq.size()) || almost_full !== (mq.size() >= AF) || full !== (mq.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL fill_status%0d: got cnt=%0d af=%b f=%b expected %0d %b %b",
                 i, count, almost_full, full, mq.size(), mq.size() >= AF, mq.size() == DEPTH);
      end
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ovf !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL overflow_drop: got ov=%b cnt=%0d expected 1 8", ovf, count);
    end
`ifdef UART_FIFO_DROPCOUNT_EN
    n_checks++;
    if (drop_count !== 16'(m_drop)) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drop); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (ack !== 1'b1 || rdata !== m_data) begin
        n_fail++; $display("FAIL fill_read%0d: got ack=%b d=%h expected 1 %h", i, ack, rdata, m_data);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1'b1, i[7:0], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h10 + i[7:0], 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'd8 || ovf !== 1'b0 || ack !== 1'b1 || rdata !== i[7:0]) begin
        n_fail++;
        $display("FAIL full_rw%0d: got cnt=%0d ov=%b ack=%b d=%h expected 8 0 1 %h", i, count, ovf, ack, rdata, i[7:0]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (ack !== 1'b1 || rdata !== m_data) begin
        n_fail++; $display("FAIL full_rw_drain%0d: got ack=%b d=%h expected 1 %h", i, ack, rdata, m_data);
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ack !== 1'b0 || unf !== 1'b1) begin
      n_fail++; $display("FAIL underflow_set: got ack=%b un=%b expected 0 1", ack, unf);
    end
    // Set wins over clear in the same cycle.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (unf !== 1'b1) begin n_fail++; $display("FAIL underflow_set_wins: got %b expected 1", unf); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b expected 0", unf); end
    // Write and read on empty: write only, no fall-through.
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ack !== 1'b0 || count !== 4'd1 || unf !== 1'b1) begin
      n_fail++; $display("FAIL no_fallthrough: got ack=%b cnt=%0d un=%b expected 0 1 1", ack, count, unf);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h80 + i[7:0], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h83 + i[7:0], 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (count !== 4'd3 || ack !== 1'b1 || rdata !== 8'h80 + i[7:0]) begin
        n_fail++;
        $display("FAIL wrap%0d: got cnt=%0d ack=%b d=%h expected 3 1 %h", i, count, ack, rdata, 8'h80 + i[7:0]);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rdata !== 8'h96 || empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_drain: got d=%h e=%b expected 96 1", rdata, empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + i[7:0], 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || ack !== 1'b0 || rdata !== m_data) begin
      n_fail++;
      $display("FAIL flush: got cnt=%0d e=%b ack=%b d=%h expected 0 1 0 %h", count, empty, ack, rdata, m_data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h31 + i[7:0], 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h35, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({count, empty, full, almost_full, ovf, unf, ack, rdata} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d e=%b f=%b af=%b ov=%b un=%b ack=%b d=%h, expected 0 1 0 0 0 0 0 00",
               count, empty, full, almost_full, ovf, unf, ack, rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ack !== 1'b1 || rdata !== 8'h55 || empty !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_read: got ack=%b d=%h e=%b expected 1 55 1", ack, rdata, empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic w, r, f, c;
      if (((i / 50) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(w, 8'($urandom), r, f, c);
      n_checks++;
      if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
          almost_full !== (mq.size() >= AF)) begin
        n_fail++;
        $display("FAIL rand_status%0d: got cnt=%0d e=%b f=%b af=%b expected cnt=%0d", i, count, empty, full, almost_full, mq.size());
      end
      n_checks++;
      if (ack !== m_ack || rdata !== m_data || ovf !== m_ovf || unf !== m_unf) begin
        n_fail++;
        $display("FAIL rand_data%0d: got ack=%b d=%h ov=%b un=%b expected %b %h %b %b",
                 i, ack, rdata, ovf, unf, m_ack, m_data, m_ovf, m_unf);
      end
`ifdef UART_FIFO_DROPCOUNT_EN
      n_checks++;
      if (drop_count !== 16'(m_drop)) begin
        n_fail++; $display("FAIL rand_drop%0d: got %0d expected %0d", i, drop_count, m_drop);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
